// File: rtl/dsram_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : dsram_arbiter
// Description : Shares the single-port data SRAM between the pipeline
//               load/store port (cpu_*, default priority) and the debug /
//               program-loader port (dbg_*). One access is granted per cycle.
//               The block tracks the single outstanding read and steers the
//               returned data to the port that issued it. A starvation counter
//               forces a debug grant after STARVE_LIMIT denied cycles.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               cpu_req/we/addr/wdata/mode/us -> cpu_gnt (comb),
//                                    cpu_rvalid/cpu_rdata (1 cycle after read)
//               dbg_req/we/addr/wdata/mode/us -> dbg_gnt (comb),
//                                    dbg_rvalid/dbg_rdata
//               dbg_starved       - forced-grant mode active
//               sram_en/we/addr/wdata/mode/write_mode/us -> SRAM request
//               sram_rdata        - SRAM read data, one cycle after a read
// Revision    : 1.0 - initial release
//==============================================================================
module dsram_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic              clk,
   input  logic              reset,
   // pipeline port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [2:0]        cpu_mode,
   input  logic              cpu_us,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   // debug port
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic [2:0]        dbg_mode,
   input  logic              dbg_us,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_starved,
   // SRAM side
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic [2:0]        sram_mode,
   output logic [2:0]        sram_write_mode,
   output logic              sram_us,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam logic [CNT_W-1:0] c_starve_limit = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             starved_q, starved_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rd_owner_q, rd_owner_d;   // 1 = dbg owns the pending read
   logic             dbg_win, cpu_win;

   // Arbitration: a starved dbg request overrides the cpu's default priority.
   always_comb begin
      dbg_win = dbg_req && (starved_q || !cpu_req);
      cpu_win = cpu_req && !dbg_win;
   end

   assign cpu_gnt     = cpu_win;
   assign dbg_gnt     = dbg_win;
   assign dbg_starved = starved_q;

   // SRAM request mux; everything is zero when nobody is granted.
   always_comb begin
      sram_en         = 1'b0;
      sram_we         = 1'b0;
      sram_addr       = '0;
      sram_wdata      = '0;
      sram_mode       = 3'd0;
      sram_write_mode = 3'd0;
      sram_us         = 1'b0;
      if (dbg_win) begin
         sram_en         = 1'b1;
         sram_we         = dbg_we;
         sram_addr       = dbg_addr;
         sram_wdata      = dbg_wdata;
         sram_mode       = dbg_mode;
         sram_write_mode = dbg_mode;
         sram_us         = dbg_us;
      end else if (cpu_win) begin
         sram_en         = 1'b1;
         sram_we         = cpu_we;
         sram_addr       = cpu_addr;
         sram_wdata      = cpu_wdata;
         sram_mode       = cpu_mode;
         sram_write_mode = cpu_mode;
         sram_us         = cpu_us;
      end
   end

   // Starvation counter and read tracking next-state.
   always_comb begin
      cnt_d      = cnt_q;
      rd_pend_d  = 1'b0;
      rd_owner_d = rd_owner_q;

      // Only an unbroken run of denied dbg cycles counts toward starvation.
      if (!dbg_req || dbg_win) begin
         cnt_d = '0;
      end else if (cnt_q < c_starve_limit) begin
         cnt_d = cnt_q + 1'b1;
      end
      starved_d = (cnt_d == c_starve_limit);

      if ((cpu_win && !cpu_we) || (dbg_win && !dbg_we)) begin
         rd_pend_d  = 1'b1;
         rd_owner_d = dbg_win;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         starved_q  <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         starved_q  <= starved_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Read data arrives from the SRAM exactly one cycle after the grant, which
   // is the cycle the pending flag is visible; steer it to the owner only.
   always_comb begin
      cpu_rvalid = rd_pend_q && !rd_owner_q;
      dbg_rvalid = rd_pend_q &&  rd_owner_q;
      cpu_rdata  = cpu_rvalid ? sram_rdata : '0;
      dbg_rdata  = dbg_rvalid ? sram_rdata : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_dsram_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_dsram_arbiter
// Description : Randomised scoreboard bench for dsram_arbiter. A behavioural
//               model decides the expected winner per cycle and queues the
//               expected read responses; a monitor pops them on rvalid.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_dsram_arbiter;

   localparam int LIMIT = 4;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  mode;
      logic        us;
   } req_t;

   typedef struct {
      int          due;
      bit          owner;   // 1 = dbg
      logic [31:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_us, cpu_gnt, cpu_rvalid;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [2:0]  cpu_mode;
   logic        dbg_req, dbg_we, dbg_us, dbg_gnt, dbg_rvalid, dbg_starved;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [2:0]  dbg_mode;
   logic        sram_en, sram_we, sram_us;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;
   logic [2:0]  sram_mode, sram_write_mode;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   rsp_t exp_q[$];

   // reference model state
   int          m_cnt = 0;
   logic [31:0] ref_mem [256];
   bit          last_cg, last_dg;

   // SRAM behavioural model
   logic [31:0] sram_mem [256];
   logic        mem_init = 1'b0;

   dsram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_mode(cpu_mode), .cpu_us(cpu_us), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_mode(dbg_mode), .dbg_us(dbg_us), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata), .dbg_starved(dbg_starved),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_mode(sram_mode), .sram_write_mode(sram_write_mode), .sram_us(sram_us),
      .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] dflt(input int i);
      return 32'(i) * 32'h9E3779B1 + 32'h0000_1357;
   endfunction

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) sram_mem[i] <= dflt(i);
         mem_init <= 1'b1;
      end else if (sram_en) begin
         if (sram_we) sram_mem[sram_addr[9:2]] <= sram_wdata;
         else         sram_rdata <= sram_mem[sram_addr[9:2]];
      end
   end

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic req_t mk(input bit req, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] mode, input bit us);
      req_t r;
      r.req = req; r.we = we; r.addr = addr; r.wdata = wdata; r.mode = mode; r.us = us;
      return r;
   endfunction

   function automatic req_t rnd_req();
      return mk(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
   endfunction

   // One clock cycle: drive, check combinational response, advance the model.
   task automatic step(input bit rst, input req_t c, input req_t d);
      int   winner;   // 0 none, 1 cpu, 2 dbg
      req_t w;
      logic [72:0] exp_sram;
      @(posedge clk);
      #2;
      reset    = rst;
      cpu_req  = c.req; cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wdata;
      cpu_mode = c.mode; cpu_us = c.us;
      dbg_req  = d.req; dbg_we = d.we; dbg_addr = d.addr; dbg_wdata = d.wdata;
      dbg_mode = d.mode; dbg_us = d.us;
      #2;
      if (d.req && m_cnt == LIMIT) winner = 2;
      else if (c.req)              winner = 1;
      else if (d.req)              winner = 2;
      else                         winner = 0;
      w = (winner == 2) ? d : c;
      exp_sram = (winner == 0) ? 73'd0 : {1'b1, w.we, w.addr, w.wdata, w.mode, w.mode, w.us};

      check("cpu_gnt", cpu_gnt, winner == 1);
      check("dbg_gnt", dbg_gnt, winner == 2);
      check("dbg_starved", dbg_starved, m_cnt == LIMIT);
      check("sram_bus", {sram_en, sram_we, sram_addr, sram_wdata, sram_mode,
                         sram_write_mode, sram_us}, exp_sram);

      if (winner != 0) begin
         if (w.we) ref_mem[w.addr[9:2]] = w.wdata;
         else if (!rst) exp_q.push_back('{cyc + 1, winner == 2, ref_mem[w.addr[9:2]]});
      end
      if (rst)                        m_cnt = 0;
      else if (d.req && winner != 2)  m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
      else                            m_cnt = 0;
      last_cg = (winner == 1);
      last_dg = (winner == 2);
   endtask

   // Response monitor
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
         end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("cpu_rvalid", cpu_rvalid, !e.owner);
            check("dbg_rvalid", dbg_rvalid, e.owner);
            check("owner_rdata", e.owner ? dbg_rdata : cpu_rdata, e.data);
            check("other_rdata", e.owner ? cpu_rdata : dbg_rdata, 0);
         end else begin
            check("idle_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
            check("idle_rdata", {cpu_rdata, dbg_rdata}, 0);
         end
      end
   end

   initial begin
      req_t idle, c, d, pc, pd;
      bit   hc, hd, rst;
      idle = mk(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 256; i++) ref_mem[i] = dflt(i);
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_mode = 0; cpu_us = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_mode = 0; dbg_us = 0;

      step(1, idle, idle);
      step(1, idle, idle);
      step(0, idle, idle);

      // cpu-only load returning 0xDEADBEEF (preloaded by a store)
      step(0, mk(1, 1, 32'h100, 32'hDEADBEEF, 3'd2, 0), idle);
      step(0, mk(1, 0, 32'h100, 0, 3'd2, 0), idle);
      step(0, idle, idle);

      // both requesting continuously: cpu x4, then forced dbg
      c = mk(1, 0, 32'h4, 0, 3'd2, 0);
      d = mk(1, 0, 32'h8, 0, 3'd1, 1);
      for (int i = 0; i < 10; i++) begin
         step(0, c, d);
         check("starve_pattern", dbg_gnt, (i % 5) == 4);
      end
      step(0, idle, idle);

      // back-to-back reads cpu, dbg, cpu
      step(0, mk(1, 0, 32'h10, 0, 3'd2, 0), idle);
      step(0, idle, mk(1, 0, 32'h20, 0, 3'd2, 0));
      step(0, mk(1, 0, 32'h30, 0, 3'd0, 1), idle);
      step(0, idle, idle);

      // dbg store
      step(0, idle, mk(1, 1, 32'h40, 32'h12345678, 3'd2, 0));
      step(0, idle, idle);

      // reset the cycle after a cpu read grant with the counter at 3
      for (int i = 0; i < 3; i++) step(0, c, d);
      step(1, idle, idle);
      check("post_reset_starved", dbg_starved, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, c, d);
         check("restart_pattern", dbg_gnt, i == 4);
      end
      // dbg drops mid-starvation, then returns: count restarts
      step(0, c, d);
      step(0, c, d);
      step(0, c, idle);
      for (int i = 0; i < 5; i++) begin
         step(0, c, d);
         check("drop_pattern", dbg_gnt, i == 4);
      end

      // randomised traffic
      hc = 0; hd = 0; pc = idle; pd = idle;
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!hc && $urandom_range(0, 3) != 0) begin pc = rnd_req(); hc = 1; end
         if (!hd && $urandom_range(0, 2) == 0) begin pd = rnd_req(); hd = 1; end
         else if (hd && $urandom_range(0, 24) == 0) hd = 0;
         c = pc; c.req = hc;
         d = pd; d.req = hd;
         step(rst, c, d);
         if (last_cg) hc = 0;
         if (last_dg) hd = 0;
      end

      step(0, idle, idle);
      step(0, idle, idle);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
